// File: rtl/dram_arb_pkg.sv
// Shared state encoding and default sizing for the DRAM request arbiter.
package dram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DRAIN  = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_REQ = 2;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/dram_arbiter_rr_picker.sv
// Combinational round-robin selector: first asserted request after 'last', wrapping.
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   grant,
   output logic               valid
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      // Offset 1 first so the previous winner is considered last.
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = IDX_W'((int'(last) + i) % NUM_REQ);
         if (!valid && req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters one-at-a-time access to a DRAM adapter.
module dram_arbiter
   import dram_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [DATA_W-1:0]         req_rdata,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [NUM_REQ-1:0]        req_err,
   output logic                      busy,
   output logic [ADDR_W-1:0]         dramAddress,
   output logic [DATA_W-1:0]         dramWriteData,
   output logic                      dramReadEnable,
   output logic                      dramWriteEnable,
   input  logic [DATA_W-1:0]         dramReadData,
   input  logic                      dramValid
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_t       state;
   logic [IDX_W-1:0] last;
   logic [IDX_W-1:0] gnt;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_vld;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req   (req),
      .last  (last),
      .grant (pick_idx),
      .valid (pick_vld)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= IDLE;
         last            <= IDX_W'(NUM_REQ - 1);
         gnt             <= '0;
         cnt             <= '0;
         req_rdata       <= '0;
         req_ack         <= '0;
         req_err         <= '0;
         busy            <= 1'b0;
         dramAddress     <= '0;
         dramWriteData   <= '0;
         dramReadEnable  <= 1'b0;
         dramWriteEnable <= 1'b0;
      end else begin
         req_ack <= '0;
         req_err <= '0;
         case (state)
            IDLE: begin
               // Wait for the adapter to be quiet before starting a new access.
               if (pick_vld && !dramValid) begin
                  gnt             <= pick_idx;
                  last            <= pick_idx;
                  dramAddress     <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                  dramWriteData   <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                  dramReadEnable  <= ~req_we[pick_idx];
                  dramWriteEnable <= req_we[pick_idx];
                  cnt             <= '0;
                  busy            <= 1'b1;
                  state           <= ACCESS;
               end
            end
            ACCESS: begin
               if (dramValid) begin
                  if (dramReadEnable) req_rdata <= dramReadData;
                  req_ack[gnt]    <= 1'b1;
                  dramReadEnable  <= 1'b0;
                  dramWriteEnable <= 1'b0;
                  state           <= DRAIN;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  req_err[gnt]    <= 1'b1;
                  dramReadEnable  <= 1'b0;
                  dramWriteEnable <= 1'b0;
                  state           <= DRAIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (!dramValid) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameters (name, default, meaning): NUM_REQ, 2, requester count; ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 1023, max ACCESS cycles before abort.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
REQ-003 Each port line SHALL read: name, direction, width, meaning.
REQ-004 clk  in  1  ui clock of DDR domain.
REQ-005 rstn  in  1  async active-low reset.
REQ-006 req  in  NUM_REQ  request per requester, held until ack/err.
REQ-007 req_we  in  NUM_REQ  1=write, 0=read.
REQ-008 req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at slice i.
REQ-009 req_wdata  in  NUM_REQ*DATA_W  packed write data.
REQ-010 req_rdata  out  DATA_W  read data, shared by all requesters, valid with ack.
REQ-011 req_ack  out  NUM_REQ  one-cycle completion pulse.
REQ-012 req_err  out  NUM_REQ  one-cycle timeout pulse.
REQ-013 busy  out  1  high whenever state != IDLE.
REQ-014 dramAddress  out  ADDR_W  to adapter.
REQ-015 dramWriteData  out  DATA_W  to adapter.
REQ-016 dramReadEnable  out  1  read request to adapter.
REQ-017 dramWriteEnable  out  1  write request to adapter.
REQ-018 dramReadData  in  DATA_W  adapter read data.
REQ-019 dramValid  in  1  adapter completion, held high while the enable stays high.

Function
REQ-020 States SHALL be IDLE, ACCESS and DRAIN, all registered; every output SHALL be a registered output.
REQ-021 IDLE: when any req is high and dramValid=0, the block SHALL grant g, the first requester with req high, searching upward from last+1 and wrapping modulo NUM_REQ.
- On grant: latch we, addr and wdata of g; set last=g; go to ACCESS.
REQ-022 ACCESS: exactly one of dramReadEnable or dramWriteEnable SHALL be high, selected by the latched we; dramAddress and dramWriteData SHALL stay constant.
REQ-023 Request at cycle N in IDLE SHALL produce an enable high at cycle N+1.
REQ-024 First cycle dramValid is sampled high in ACCESS:
- capture dramReadData into req_rdata (reads only; writes leave req_rdata unchanged);
- pulse req_ack[g] in the next cycle;
- drop the enables in that same next cycle;
- go to DRAIN.
REQ-025 ACCESS cycle counter SHALL be cleared on entry and saturate at TIMEOUT.
- When it reaches TIMEOUT with dramValid still 0: pulse req_err[g], drop the enables, go to DRAIN.
- req_ack SHALL NOT be pulsed for that transaction.
REQ-026 DRAIN: enables SHALL stay low; go to IDLE on the first cycle dramValid=0, with a minimum of one DRAIN cycle.
REQ-027 Deasserting req[g] during ACCESS SHALL NOT abort the transaction; ack is still pulsed.
REQ-028 req_ack and req_err SHALL never be high in the same cycle, and at most one bit of each SHALL be high at once.
REQ-029 dramReadEnable and dramWriteEnable SHALL never be high together.
REQ-030 A request raised during ACCESS or DRAIN SHALL wait for IDLE; no request is lost while it remains held.
REQ-031 When both requesters are continuously high, grants SHALL alternate 0,1,0,1,...

Reset
REQ-032 rstn low SHALL asynchronously force:
- state=IDLE, last=NUM_REQ-1;
- all outputs and the counter to 0.
REQ-033 Reset mid-ACCESS SHALL drop the enables immediately with no ack or err; the adapter is reset from the same source.

Structure
REQ-034 Package dram_arb_pkg SHALL hold the state enum (IDLE, ACCESS, DRAIN) and the default parameter constants.
REQ-035 Sub-module rr_picker (combinational round-robin priority selector: req vector and last in, grant index and valid out) SHALL be instantiated once.

Verification
REQ-036 Single read: req[0]=1, we=0, addr=0, adapter returns 0x000004D2 -> one ack[0] pulse, req_rdata=0x000004D2, both enables low afterwards, busy=0 after DRAIN.
REQ-037 Write then read-back: req[1] writes 1234 to addr 0x10, then req[1] reads 0x10 -> ack[1] for each transaction, read returns 1234, dramWriteEnable high only during the write.
REQ-038 Contention: req=2'b11 held for 4 transactions -> grant order 0,1,0,1; no cycle with both enables high.
REQ-039 Timeout: adapter never asserts dramValid, TIMEOUT=15 -> err[g] pulses 16 cycles after the enable rises, no ack, state returns to IDLE.
REQ-040 Reset mid-ACCESS: rstn low while dramReadEnable=1 -> enables drop without a clock edge; after release, the first grant goes to requester 0.
